prog_loader: RTL and testbench

- Parametrised instruction-memory loader that replaces bench-driven W/OVERWRITE/ADDR/DATA_WR sequencing with a self-timed hardware block.
- Accepts a valid/ready stream of DATA_SIZE-bit instruction words and writes them to consecutive addresses starting at a programmable base, with wrap-around.
- Holds the CPU stalled during the load, then optionally reads the region back and compares a checksum.
- Sits between the host/debug port and the top_level memory write port.

---
 rtl/prog_loader_if.sv | 25 ++
 rtl/prog_loader.sv | 134 +++++++++++++
 tb/tb_prog_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_if.sv
// Stream and memory-port bundle for prog_loader.
// The master view belongs to the loader, the slave view to the host/memory side.
interface prog_loader_if #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 5
);
    logic                 s_valid;
    logic [DATA_SIZE-1:0] s_data;
    logic                 s_ready;
    logic                 mem_w;
    logic                 mem_overwrite;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0] mem_wdata;
    logic [DATA_SIZE-1:0] mem_rdata;

    modport master (
        input  s_valid, s_data, mem_rdata,
        output s_ready, mem_w, mem_overwrite, mem_addr, mem_wdata
    );

    modport slave (
        output s_valid, s_data, mem_rdata,
        input  s_ready, mem_w, mem_overwrite, mem_addr, mem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Self-timed instruction-memory loader: streams words into consecutive addresses
// from a base with wrap-around, holds the CPU meanwhile, optionally verifies a checksum.
module prog_loader #(
    parameter int unsigned DATA_SIZE = 16,
    parameter int unsigned ADDR_SIZE = 5,
    parameter int unsigned RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [ADDR_SIZE-1:0] base_addr,
    input  logic [ADDR_SIZE:0]   word_count,
    input  logic                 verify_en,
    prog_loader_if.master        bus,
    output logic                 cpu_hold,
    output logic                 busy,
    output logic                 done,
    output logic                 error,
    output logic [DATA_SIZE-1:0] checksum
);

    typedef enum logic [1:0] {IDLE, LOAD, VERIFY, DONE} state_t;

    localparam logic [ADDR_SIZE:0]   DEPTH   = {1'b1, {ADDR_SIZE{1'b0}}};
    localparam logic [ADDR_SIZE:0]   CNT_ONE = (ADDR_SIZE+1)'(1);
    localparam logic [ADDR_SIZE-1:0] PTR_ONE = ADDR_SIZE'(1);

    state_t               state, state_nx;
    logic [ADDR_SIZE:0]   remaining, issue_left, ret_left;
    logic [ADDR_SIZE-1:0] base_q, wptr, mem_addr_q;
    logic                 verify_q, mem_w_q, done_q, error_q;
    logic [DATA_SIZE-1:0] mem_wdata_q, checksum_q, vsum;
    logic [RD_LAT-1:0]    rd_vld;
    logic                 count_zero, count_big;
    logic                 s_ready_c, handshake, rd_issue;

    assign count_zero = (word_count == '0);
    assign count_big  = (word_count > DEPTH);
    assign handshake  = s_ready_c && bus.s_valid;
    assign rd_issue   = (state == VERIFY) && (issue_left != '0);

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) state <= IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        busy      = (state != IDLE);
        cpu_hold  = (state != IDLE);
        s_ready_c = (state == LOAD) && (remaining != '0);
        case (state)
            IDLE:    if (start) state_nx = (count_zero || count_big) ? DONE : LOAD;
            LOAD:    if (remaining == '0) state_nx = verify_q ? VERIFY : DONE;
            VERIFY:  if (ret_left == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            remaining   <= '0;
            issue_left  <= '0;
            ret_left    <= '0;
            base_q      <= '0;
            wptr        <= '0;
            mem_addr_q  <= '0;
            verify_q    <= 1'b0;
            mem_w_q     <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            mem_wdata_q <= '0;
            checksum_q  <= '0;
            vsum        <= '0;
            rd_vld      <= '0;
        end else begin
            mem_w_q   <= 1'b0;
            done_q    <= (state == DONE);
            rd_vld[0] <= rd_issue;
            for (int unsigned i = 1; i < RD_LAT; i++) rd_vld[i] <= rd_vld[i-1];

            case (state)
                IDLE: begin
                    if (start) begin
                        base_q     <= base_addr;
                        wptr       <= base_addr;
                        verify_q   <= verify_en;
                        remaining  <= word_count;
                        issue_left <= word_count;
                        ret_left   <= word_count;
                        checksum_q <= '0;
                        vsum       <= '0;
                        error_q    <= count_big;
                    end
                end
                LOAD: begin
                    if (handshake) begin
                        mem_w_q     <= 1'b1;
                        mem_addr_q  <= wptr;
                        mem_wdata_q <= bus.s_data;
                        checksum_q  <= checksum_q + bus.s_data;
                        wptr        <= wptr + PTR_ONE;
                        remaining   <= remaining - CNT_ONE;
                    end
                    // Preload the first read address so VERIFY issues a read every cycle.
                    if (remaining == '0 && verify_q) mem_addr_q <= base_q;
                end
                VERIFY: begin
                    if (rd_issue) begin
                        mem_addr_q <= mem_addr_q + PTR_ONE;
                        issue_left <= issue_left - CNT_ONE;
                    end
                    if (rd_vld[RD_LAT-1]) begin
                        vsum     <= vsum + bus.mem_rdata;
                        ret_left <= ret_left - CNT_ONE;
                    end
                    if (ret_left == '0) error_q <= (vsum != checksum_q);
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready       = s_ready_c;
    assign bus.mem_w         = mem_w_q;
    assign bus.mem_overwrite = mem_w_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;
    assign done              = done_q;
    assign error             = error_q;
    assign checksum          = checksum_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: two instances (RD_LAT 1 and 3) share the stream,
// each with its own behavioural memory that can corrupt address 2 on readback.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rstn, start, verify_en, s_valid, corrupt;
    logic [4:0]  base_addr;
    logic [5:0]  word_count;
    logic [15:0] s_data;
    logic        busy1, hold1, done1, err1, busy3, hold3, done3, err3;
    logic [15:0] cs1, cs3;

    int passes = 0;
    int total  = 0;

    always #5 clk = ~clk;

    prog_loader_if #(.DATA_SIZE(16), .ADDR_SIZE(5)) bus1 ();
    prog_loader_if #(.DATA_SIZE(16), .ADDR_SIZE(5)) bus3 ();

    assign bus1.s_valid = s_valid;
    assign bus1.s_data  = s_data;
    assign bus3.s_valid = s_valid;
    assign bus3.s_data  = s_data;

    prog_loader #(.DATA_SIZE(16), .ADDR_SIZE(5), .RD_LAT(1)) dut1 (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .verify_en(verify_en), .bus(bus1),
        .cpu_hold(hold1), .busy(busy1), .done(done1), .error(err1), .checksum(cs1)
    );

    prog_loader #(.DATA_SIZE(16), .ADDR_SIZE(5), .RD_LAT(3)) dut3 (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .word_count(word_count), .verify_en(verify_en), .bus(bus3),
        .cpu_hold(hold3), .busy(busy3), .done(done3), .error(err3), .checksum(cs3)
    );

    // Behavioural memories; readback of address 2 is flipped when corrupt is set
    logic [15:0] mem1 [32];
    logic [15:0] mem3 [32];
    logic [15:0] rd1, p0, p1, p2;

    always @(posedge clk) begin
        if (bus1.mem_w) mem1[bus1.mem_addr] <= bus1.mem_wdata;
        rd1 <= mem1[bus1.mem_addr] ^ ((corrupt && bus1.mem_addr == 5'd2) ? 16'h0100 : 16'h0000);
        if (bus3.mem_w) mem3[bus3.mem_addr] <= bus3.mem_wdata;
        p0 <= mem3[bus3.mem_addr] ^ ((corrupt && bus3.mem_addr == 5'd2) ? 16'h0100 : 16'h0000);
        p1 <= p0;
        p2 <= p1;
    end
    assign bus1.mem_rdata = rd1;
    assign bus3.mem_rdata = p2;

    // Write / done log of instance 1
    int          cyc    = 0;
    int          wr_n   = 0;
    int          done_n = 0;
    logic [4:0]  wr_a [128];
    logic [15:0] wr_d [128];
    int          wr_c [128];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus1.mem_w === 1'b1 && wr_n < 128) begin
            wr_a[wr_n] <= bus1.mem_addr;
            wr_d[wr_n] <= bus1.mem_wdata;
            wr_c[wr_n] <= cyc;
            wr_n       <= wr_n + 1;
        end
        if (done1 === 1'b1) done_n <= done_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [4:0] b, input logic [5:0] n, input logic v);
        base_addr  = b;
        word_count = n;
        verify_en  = v;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] d, input int gap, input logic [4:0] a);
        int guard;
        for (int g = 0; g < gap; g++) begin
            s_valid = 1'b0;
            s_data  = 16'hDEAD;
            tick();
            check("gap_mem_w", bus1.mem_w, 0);
        end
        s_valid = 1'b1;
        s_data  = d;
        guard   = 0;
        while (bus1.s_ready !== 1'b1 && guard < 50) begin
            tick();
            guard++;
        end
        check("s_ready_seen", bus1.s_ready, 1);
        tick();
        s_valid = 1'b0;
        s_data  = 16'hBEEF;
        check("wr_en", bus1.mem_w, 1);
        check("wr_ovw", bus1.mem_overwrite, 1);
        check("wr_addr", bus1.mem_addr, a);
        check("wr_data", bus1.mem_wdata, d);
    endtask

    task automatic wait_done(input string tag, input bit third);
        int lat;
        lat = 0;
        while ((third ? done3 : done1) !== 1'b1 && lat < 300) begin
            tick();
            lat++;
        end
        check({tag, "_done_seen"}, third ? done3 : done1, 1);
        check({tag, "_busy_off"}, third ? busy3 : busy1, 0);
        check({tag, "_hold_off"}, third ? hold3 : hold1, 0);
    endtask

    initial begin
        int w0, d0, ones;
        int hits [32];

        rstn = 1'b1; start = 1'b0; verify_en = 1'b0; s_valid = 1'b0; corrupt = 1'b0;
        base_addr = '0; word_count = '0; s_data = '0;
        tick(); tick();
        check("rst_busy", busy1, 0);
        check("rst_hold", hold1, 0);
        check("rst_done", done1, 0);
        check("rst_err", err1, 0);
        check("rst_cs", cs1, 0);
        check("rst_addr", bus1.mem_addr, 0);
        check("rst_wdata", bus1.mem_wdata, 0);
        check("rst_sready", bus1.s_ready, 0);
        rstn = 1'b0;
        tick();

        // Async reset in the cycle a write is on the bus
        do_start(5'd5, 6'd3, 1'b0);
        send_word(16'h1234, 0, 5'd5);
        check("pre_rst_sready", bus1.s_ready, 1);
        #2 rstn = 1'b1;
        #1;
        check("arst_mem_w", bus1.mem_w, 0);
        check("arst_sready", bus1.s_ready, 0);
        check("arst_hold", hold1, 0);
        check("arst_busy", busy1, 0);
        tick();
        rstn = 1'b0;
        tick();
        check("post_rst_busy", busy1, 0);
        check("post_rst_sready", bus1.s_ready, 0);

        // Basic back-to-back load
        w0 = wr_n; d0 = done_n;
        do_start(5'd0, 6'd3, 1'b0);
        check("basic_hold_start", hold1, 1);
        check("basic_busy_start", busy1, 1);
        send_word(16'h5021, 0, 5'd0);
        send_word(16'h1032, 0, 5'd1);
        send_word(16'h9110, 0, 5'd2);
        check("basic_hold_end", hold1, 1);
        wait_done("basic", 1'b0);
        check("basic_cs", cs1, 16'hF163);
        check("basic_err", err1, 0);
        tick();
        check("basic_done_pulse", done1, 0);
        check("basic_wr_count", wr_n - w0, 3);
        check("basic_consec1", wr_c[w0+1] - wr_c[w0], 1);
        check("basic_consec2", wr_c[w0+2] - wr_c[w0+1], 1);
        check("basic_done_count", done_n - d0, 1);

        // Stalled stream with junk on s_data during gaps
        w0 = wr_n;
        do_start(5'd12, 6'd3, 1'b0);
        send_word(16'h5021, 0, 5'd12);
        send_word(16'h1032, 2, 5'd13);
        send_word(16'h9110, 4, 5'd14);
        wait_done("stall", 1'b0);
        check("stall_cs", cs1, 16'hF163);
        check("stall_wr_count", wr_n - w0, 3);
        check("stall_mem12", mem1[12], 16'h5021);
        check("stall_mem13", mem1[13], 16'h1032);
        check("stall_mem14", mem1[14], 16'h9110);

        // Wrap-around from the top address
        w0 = wr_n;
        do_start(5'd31, 6'd2, 1'b0);
        send_word(16'hAAAA, 0, 5'd31);
        send_word(16'h5555, 0, 5'd0);
        wait_done("wrap", 1'b0);
        check("wrap_cs", cs1, 16'hFFFF);
        check("wrap_wr_count", wr_n - w0, 2);

        // Verify, clean readback (sum 0xC20C)
        w0 = wr_n;
        do_start(5'd0, 6'd4, 1'b1);
        send_word(16'h0001, 0, 5'd0);
        send_word(16'h0203, 0, 5'd1);
        send_word(16'h4000, 0, 5'd2);
        send_word(16'h8008, 0, 5'd3);
        wait_done("ver1", 1'b0);
        check("ver1_err", err1, 0);
        check("ver1_cs", cs1, 16'hC20C);
        wait_done("ver3", 1'b1);
        check("ver3_err", err3, 0);
        check("ver3_cs", cs3, 16'hC20C);
        check("ver_wr_count", wr_n - w0, 4);

        // Verify with address 2 corrupted on readback
        corrupt = 1'b1;
        do_start(5'd0, 6'd4, 1'b1);
        send_word(16'h0001, 0, 5'd0);
        send_word(16'h0203, 0, 5'd1);
        send_word(16'h4000, 0, 5'd2);
        send_word(16'h8008, 0, 5'd3);
        wait_done("bad1", 1'b0);
        check("bad1_err", err1, 1);
        wait_done("bad3", 1'b1);
        check("bad3_err", err3, 1);
        corrupt = 1'b0;

        // Zero count: done two cycles after start, error cleared
        w0 = wr_n;
        do_start(5'd9, 6'd0, 1'b0);
        check("zero_err_cleared", err1, 0);
        check("zero_err3_cleared", err3, 0);
        check("zero_done_early", done1, 0);
        tick();
        check("zero_done", done1, 1);
        check("zero_busy", busy1, 0);
        tick();
        check("zero_wr_count", wr_n - w0, 0);

        // Oversize count
        w0 = wr_n;
        do_start(5'd0, 6'd33, 1'b0);
        check("big_sready", bus1.s_ready, 0);
        tick();
        check("big_done", done1, 1);
        check("big_err", err1, 1);
        tick();
        check("big_wr_count", wr_n - w0, 0);

        // Full depth from base 7, with an ignored start while busy
        w0 = wr_n;
        do_start(5'd7, 6'd32, 1'b0);
        check("full_err_cleared", err1, 0);
        do_start(5'd0, 6'd0, 1'b0);
        check("busy_start_busy", busy1, 1);
        check("busy_start_sready", bus1.s_ready, 1);
        for (int i = 0; i < 32; i++) send_word(16'(16'h0100 + i), 0, 5'(7 + i));
        wait_done("full", 1'b0);
        check("full_cs", cs1, 16'h21F0);
        check("full_err", err1, 0);
        tick();
        check("full_wr_count", wr_n - w0, 32);
        for (int i = 0; i < 32; i++) hits[i] = 0;
        for (int k = w0; k < wr_n; k++) hits[wr_a[k]]++;
        ones = 0;
        for (int i = 0; i < 32; i++) if (hits[i] == 1) ones++;
        check("full_each_once", ones, 32);
        check("full_mem0", mem1[0], 16'h0119);
        check("full_mem31", mem1[31], 16'h0118);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
